sa_poll_sched: RTL and testbench

SA_POLL_SCHED -- requirements
Module: sa_poll_sched

---
 rtl/sa_poll_sched.sv | 144 ++++++++++++++
 tb/tb_sa_poll_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_poll_sched.sv
// rtl/sa_poll_sched.sv - round-robin card poll scheduler with response window and error counters
// Build option SA_POLL_RETRY_EN: a timed-out slot is re-polled once before it is reported.
module sa_poll_sched #(
  parameter logic [7:0]  ID_FIRST    = 8'd1,
  parameter logic [7:0]  ID_LAST     = 8'd16,
  parameter logic [15:0] TIMEOUT_CYC = 16'd2000,
  parameter logic [7:0]  GAP_CYC     = 8'd16
) (
  input  logic        sys_clk,
  input  logic        glbl_rst,
  input  logic        init_done,
  input  logic        sched_en,
  output logic        ack_tx_en,
  output logic [7:0]  id_now,
  input  logic        got_frame,
  input  logic [7:0]  frame_id,
  input  logic        sn_error,
  output logic        slot_ok,
  output logic        slot_timeout,
  output logic        stray_frame,
  output logic        cycle_done,
  output logic [15:0] timeout_cnt,
  output logic [15:0] sn_err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_POLL,
    S_WAIT_RX,
    S_NEXT
  } state_t;

  state_t      state;
  logic [7:0]  gap_cnt;
  logic [15:0] win_cnt;
  logic        match;
  logic        win_last;
`ifdef SA_POLL_RETRY_EN
  logic        retried;
`endif

  assign match    = got_frame && (frame_id == id_now);
  assign win_last = (win_cnt == TIMEOUT_CYC - 16'd1);

  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      state        <= S_IDLE;
      id_now       <= ID_FIRST;
      gap_cnt      <= 8'd0;
      win_cnt      <= 16'd0;
      ack_tx_en    <= 1'b0;
      slot_ok      <= 1'b0;
      slot_timeout <= 1'b0;
      stray_frame  <= 1'b0;
      cycle_done   <= 1'b0;
      timeout_cnt  <= 16'd0;
      sn_err_cnt   <= 16'd0;
`ifdef SA_POLL_RETRY_EN
      retried      <= 1'b0;
`endif
    end else begin
      ack_tx_en    <= 1'b0;
      slot_ok      <= 1'b0;
      slot_timeout <= 1'b0;
      cycle_done   <= 1'b0;
      // Any frame that is not the awaited response counts as stray, whatever the state.
      stray_frame  <= got_frame && !((state == S_WAIT_RX) && (frame_id == id_now));

      if (sn_error && (sn_err_cnt != 16'hFFFF)) begin
        sn_err_cnt <= sn_err_cnt + 16'd1;
      end

      if (!init_done) begin
        state <= S_IDLE;
`ifdef SA_POLL_RETRY_EN
        retried <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (sched_en) begin
              id_now  <= ID_FIRST;
              gap_cnt <= 8'd0;
              state   <= S_GAP;
            end
          end
          S_GAP: begin
            if (gap_cnt == GAP_CYC - 8'd1) begin
              state <= S_POLL;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          S_POLL: begin
            ack_tx_en <= 1'b1;
            win_cnt   <= 16'd0;
            state     <= S_WAIT_RX;
          end
          S_WAIT_RX: begin
            // A match on the final window cycle takes priority over the timeout.
            if (match) begin
              slot_ok <= 1'b1;
              state   <= S_NEXT;
            end else if (win_last) begin
`ifdef SA_POLL_RETRY_EN
              if (!retried) begin
                retried <= 1'b1;
                gap_cnt <= 8'd0;
                state   <= S_GAP;
              end else begin
                slot_timeout <= 1'b1;
                if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
                state <= S_NEXT;
              end
`else
              slot_timeout <= 1'b1;
              if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
              state <= S_NEXT;
`endif
            end else begin
              win_cnt <= win_cnt + 16'd1;
            end
          end
          S_NEXT: begin
            if (id_now == ID_LAST) begin
              cycle_done <= 1'b1;
              id_now     <= ID_FIRST;
            end else begin
              id_now <= id_now + 8'd1;
            end
`ifdef SA_POLL_RETRY_EN
            retried <= 1'b0;
`endif
            gap_cnt <= 8'd0;
            state   <= sched_en ? S_GAP : S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sa_poll_sched.sv
// tb/tb_sa_poll_sched.sv - randomized scoreboard bench for sa_poll_sched (both SA_POLL_RETRY_EN builds)
// The model predicts each output pulse as an absolute cycle number from the slot timing rules.
module tb_sa_poll_sched;

  localparam logic [7:0] ID_FIRST = 8'd1;
  localparam logic [7:0] ID_LAST  = 8'd3;
  localparam int         T        = 10;
  localparam int         GAP      = 4;

  localparam logic [4:0] P_ACK   = 5'b00001;
  localparam logic [4:0] P_OK    = 5'b00010;
  localparam logic [4:0] P_TO    = 5'b00100;
  localparam logic [4:0] P_STRAY = 5'b01000;
  localparam logic [4:0] P_CDONE = 5'b10000;

  logic        sys_clk = 1'b0;
  logic        glbl_rst, init_done, sched_en, got_frame, sn_error;
  logic [7:0]  frame_id;
  logic        ack_tx_en, slot_ok, slot_timeout, stray_frame, cycle_done;
  logic [7:0]  id_now;
  logic [15:0] timeout_cnt, sn_err_cnt;

  sa_poll_sched #(
    .ID_FIRST(ID_FIRST), .ID_LAST(ID_LAST), .TIMEOUT_CYC(16'(T)), .GAP_CYC(8'(GAP))
  ) dut (
    .sys_clk(sys_clk), .glbl_rst(glbl_rst), .init_done(init_done), .sched_en(sched_en),
    .ack_tx_en(ack_tx_en), .id_now(id_now), .got_frame(got_frame), .frame_id(frame_id),
    .sn_error(sn_error), .slot_ok(slot_ok), .slot_timeout(slot_timeout),
    .stray_frame(stray_frame), .cycle_done(cycle_done), .timeout_cnt(timeout_cnt),
    .sn_err_cnt(sn_err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          cyc;
    logic [4:0]  pulses;
    logic [7:0]  id;
    logic [15:0] tcnt;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_to = 0;
  int         n_sn = 0;
  int         sn_mode = 0;
  int         a_cyc;
  logic [7:0] cur_id;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    logic [4:0] p;
    ev_t e;
    p = {cycle_done, stray_frame, slot_timeout, slot_ok, ack_tx_en};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_chk++;
      $display("FAIL missed_event cyc=%0d: got no pulse, expected pulses=%b id=%0d", e.cyc, e.pulses, e.id);
    end
    if ((|p) === 1'b1) begin
      n_chk++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        if (p === e.pulses && id_now === e.id && timeout_cnt === e.tcnt) n_pass++;
        else $display("FAIL event cyc=%0d: got pulses=%b id=%0d tcnt=%0d, expected pulses=%b id=%0d tcnt=%0d",
                      cyc, p, id_now, timeout_cnt, e.pulses, e.id, e.tcnt);
      end else begin
        $display("FAIL unexpected_pulse cyc=%0d: got pulses=%b id=%0d, expected none", cyc, p, id_now);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    got_frame = 1'b0;
    frame_id  = 8'd0;
    case (sn_mode)
      0:       sn_error = 1'b0;
      1:       sn_error = ($urandom % 4) == 0;
      default: sn_error = 1'b1;
    endcase
    if (sn_error) n_sn++;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_ev(input int c, input logic [4:0] p, input logic [7:0] id);
    ev_t e;
    e.cyc = c; e.pulses = p; e.id = id; e.tcnt = 16'(n_to);
    exp_q.push_back(e);
  endtask

  // mode: 0 plain, 1 sched_en drop then re-enable, 2 init_done drop in gap,
  // 3 reset inside the window, 4 sched_en drop and stay idle, 5 stray frame during gap
  task automatic do_slot(input int d, input int s, input logic [7:0] sid, input int mode);
    int         r;
    logic [7:0] nid;
    push_ev(a_cyc, P_ACK, cur_id);
    wait_until(a_cyc);
    if (mode == 3) begin
      wait_until(a_cyc + 2);
      glbl_rst = 1'b1;
      sn_mode  = 0;
      tick();
      glbl_rst = 1'b0;
      n_to = 0;
      n_sn = 0;
      check("rst_mid_tcnt", 32'(timeout_cnt), 32'd0);
      check("rst_mid_sncnt", 32'(sn_err_cnt), 32'd0);
      check("rst_mid_id", 32'(id_now), 32'(ID_FIRST));
      sn_mode = 1;
      cur_id  = ID_FIRST;
      a_cyc   = cyc + GAP + 2;
      return;
    end
    if (mode == 1 || mode == 4) sched_en = 1'b0;
    if (s >= 0) push_ev(a_cyc + s + 1, P_STRAY, cur_id);
    if (d >= 0) begin
      r = a_cyc + d + 1;
      push_ev(r, P_OK, cur_id);
    end else begin
`ifdef SA_POLL_RETRY_EN
      push_ev(a_cyc + T + GAP + 1, P_ACK, cur_id);
      r = a_cyc + T + GAP + 1 + T;
`else
      r = a_cyc + T;
`endif
      if (n_to < 65535) n_to++;
      push_ev(r, P_TO, cur_id);
    end
    nid = (cur_id == ID_LAST) ? ID_FIRST : cur_id + 8'd1;
    if (cur_id == ID_LAST) push_ev(r + 1, P_CDONE, nid);
    if (s >= 0) begin
      wait_until(a_cyc + s);
      got_frame = 1'b1;
      frame_id  = sid;
    end
    if (d >= 0) begin
      wait_until(a_cyc + d);
      got_frame = 1'b1;
      frame_id  = cur_id;
    end
    wait_until(r);
    case (mode)
      1: begin
        wait_until(r + 2);
        sched_en = 1'b1;
        a_cyc  = cyc + GAP + 2;
        cur_id = ID_FIRST;
      end
      2: begin
        wait_until(r + 2);
        init_done = 1'b0;
        tick();
        init_done = 1'b1;
        a_cyc  = cyc + GAP + 2;
        cur_id = ID_FIRST;
      end
      4: cur_id = ID_FIRST;
      5: begin
        push_ev(r + 3, P_STRAY, nid);
        wait_until(r + 2);
        got_frame = 1'b1;
        frame_id  = 8'($urandom);
        a_cyc  = r + GAP + 2;
        cur_id = nid;
      end
      default: begin
        a_cyc  = r + GAP + 2;
        cur_id = nid;
      end
    endcase
  endtask

  initial begin
    glbl_rst = 1'b1; init_done = 1'b0; sched_en = 1'b0;
    got_frame = 1'b0; frame_id = 8'd0; sn_error = 1'b0;
    repeat (3) tick();
    check("reset_id", 32'(id_now), 32'(ID_FIRST));
    check("reset_tcnt", 32'(timeout_cnt), 32'd0);
    check("reset_sncnt", 32'(sn_err_cnt), 32'd0);
    check("reset_pulses", 32'({cycle_done, stray_frame, slot_timeout, slot_ok, ack_tx_en}), 32'd0);
    glbl_rst = 1'b0;
    tick();

    init_done = 1'b1;
    sched_en  = 1'b1;
    sn_mode   = 1;
    a_cyc  = cyc + GAP + 2;
    cur_id = ID_FIRST;

    for (int k = 0; k < 6; k++) do_slot(5, -1, 8'd0, 0);
    do_slot(-1, -1, 8'd0, 0);
    do_slot(6, 2, 8'd7, 0);
    do_slot(T - 1, -1, 8'd0, 0);
    do_slot(3, -1, 8'd0, 2);
    do_slot(4, -1, 8'd0, 3);
    do_slot(2, -1, 8'd0, 1);

    for (int k = 0; k < 150; k++) begin
      int d, s, lim, rr, m;
      logic [7:0] sid;
      rr = int'($urandom % 100);
      if ($urandom % 4 == 0) d = -1;
      else if ($urandom % 5 == 0) d = T - 1;
      else d = int'($urandom % T);
      lim = (d < 0) ? T - 2 : d - 1;
      s = -1;
      if (lim >= 0 && ($urandom % 3) == 0) s = int'($urandom % (lim + 1));
      sid = cur_id ^ (8'd1 + 8'($urandom % 255));
      m = (rr < 5) ? 1 : (rr < 10) ? 2 : (rr < 15) ? 3 : (rr < 30) ? 5 : 0;
      do_slot(d, s, sid, m);
    end
    do_slot(1, -1, 8'd0, 4);

    sn_mode = 0;
    repeat (2) tick();
    check("sn_random_count", 32'(sn_err_cnt), 32'((n_sn > 65535) ? 65535 : n_sn));
    sn_mode = 2;
    while (n_sn < 65534) tick();
    sn_mode = 0;
    tick();
    check("sn_below_sat", 32'(sn_err_cnt), 32'h0000FFFE);
    sn_mode = 2;
    while (n_sn < 70000) tick();
    sn_mode = 0;
    tick();
    check("sn_saturated", 32'(sn_err_cnt), 32'h0000FFFF);

    repeat (40) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
